ps2_transmit: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, reset 0xFF) to the keyboard.
- Uses open-collector signalling. The block only ever drives a line low or releases it.
- Sits beside ps2_receive on the same ps2c/ps2d pins. tx_idle gates the receiver's read enable, so the receiver never parses the host's own frame.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_clk_filter.sv | 41 ++++
 rtl/ps2_transmit.sv | 141 ++++++++++++++
 tb/tb_ps2_transmit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the frame builder used by the host-to-device path.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      RTS          = 3'd1,
      START        = 3'd2,
      DATA         = 3'd3,
      STOP         = 3'd4,
      WAIT_RELEASE = 3'd5
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_ACK         = 8'hFA;

   // Odd parity on top of the data byte, shifted out LSB first.
   function automatic logic [8:0] ps2_frame(input logic [7:0] data);
      return {~^data, data};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the sampled PS/2 clock pin and reports one-cycle fall/rise
// events of the cleaned clock; shared by the transmit and receive paths.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2c,
   output logic ps2c_filt,
   output logic fall,
   output logic rise
);

   logic [FILTER_LEN-1:0] filter_reg;
   logic [FILTER_LEN-1:0] filter_next;
   logic                  filt_next;

   // The filtered level only moves once the whole window agrees.
   always_comb begin
      filter_next = {ps2c, filter_reg[FILTER_LEN-1:1]};
      filt_next   = ps2c_filt;
      if (&filter_next)
         filt_next = 1'b1;
      else if (~|filter_next)
         filt_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         filter_reg <= '1;
         ps2c_filt  <= 1'b1;
      end else begin
         filter_reg <= filter_next;
         ps2c_filt  <= filt_next;
      end
   end

   assign fall = ps2c_filt & ~filt_next;
   assign rise = ~ps2c_filt & filt_next;

endmodule

// File: rtl/ps2_transmit.sv
// Host-to-device PS/2 transmitter: request-to-send, start/data/parity/stop
// clocked out by the device, then ACK check with an overall timeout.
module ps2_transmit
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   output logic       ps2c_drive_low,
   output logic       ps2d_drive_low,
   output logic       tx_idle,
   output logic       done_tick,
   output logic       err_tick
);

   localparam int RTS_W = ($clog2(INHIBIT_CYCLES) > 0) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TO_W  = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t    state_reg, state_next;
   logic [8:0]       sr_reg, sr_next;
   logic [3:0]       n_reg, n_next;
   logic [RTS_W-1:0] rts_cnt, rts_next;
   logic [TO_W-1:0]  to_cnt, to_next;
   logic             ack_reg, ack_next;
   logic             fall, rise, filt_unused;
   logic             active, timeout;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk      (clk),
      .reset_n  (reset_n),
      .ps2c     (ps2c),
      .ps2c_filt(filt_unused),
      .fall     (fall),
      .rise     (rise)
   );

   assign active  = (state_reg == START) || (state_reg == DATA) ||
                    (state_reg == STOP)  || (state_reg == WAIT_RELEASE);
   assign timeout = active && (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         sr_reg    <= '0;
         n_reg     <= '0;
         rts_cnt   <= '0;
         to_cnt    <= '0;
         ack_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sr_reg    <= sr_next;
         n_reg     <= n_next;
         rts_cnt   <= rts_next;
         to_cnt    <= to_next;
         ack_reg   <= ack_next;
      end
   end

   // Timeout overrides whatever edge the device produced in the same cycle.
   always_comb begin
      state_next = state_reg;
      sr_next    = sr_reg;
      n_next     = n_reg;
      rts_next   = rts_cnt;
      to_next    = to_cnt;
      ack_next   = ack_reg;
      done_tick  = 1'b0;
      err_tick   = 1'b0;
      if (active && (to_cnt != TO_LAST))
         to_next = to_cnt + TO_W'(1);
      case (state_reg)
         IDLE: begin
            if (wr_ps2) begin
               sr_next    = ps2_frame(din);
               rts_next   = '0;
               state_next = RTS;
            end
         end
         RTS: begin
            if (rts_cnt == RTS_LAST) begin
               to_next    = '0;
               state_next = START;
            end else begin
               rts_next = rts_cnt + RTS_W'(1);
            end
         end
         START: begin
            if (fall) begin
               n_next     = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (fall) begin
               if (n_reg == 4'd8) begin
                  state_next = STOP;
               end else begin
                  sr_next = {1'b0, sr_reg[8:1]};
                  n_next  = n_reg + 4'd1;
               end
            end
         end
         STOP: begin
            if (fall) begin
               ack_next   = ~ps2d;
               state_next = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (rise) begin
               state_next = IDLE;
               done_tick  = ack_reg;
               err_tick   = ~ack_reg;
            end
         end
         default: state_next = IDLE;
      endcase
      if (timeout) begin
         state_next = IDLE;
         done_tick  = 1'b0;
         err_tick   = 1'b1;
      end
   end

   // Pin drives come from registers only so the open-collector lines never glitch.
   assign ps2c_drive_low = (state_reg == RTS);
   assign ps2d_drive_low = ((state_reg == RTS) && (rts_cnt == RTS_LAST)) ||
                           (!timeout && ((state_reg == START) ||
                                         ((state_reg == DATA) && !sr_reg[0])));
   assign tx_idle        = (state_reg == IDLE);

endmodule

// File: tb/tb_ps2_transmit.sv
// Bench for ps2_transmit: an open-collector device model clocks frames out,
// compared against a frame model built from the PS/2 framing rules.
module tb_ps2_transmit;

   localparam int INHIBIT = 1000;
   localparam int FLEN    = 8;
   localparam int TIMEOUT = 3000;
   localparam int HALF    = 40;

   typedef struct {
      logic [7:0]  din;
      logic        ack;
      logic [10:0] exp_bits;
      int          exp_done;
      int          exp_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_ps2 = 1'b0;
   logic [7:0] din = 8'h00;
   logic       ps2c, ps2d;
   logic       ps2c_drive_low, ps2d_drive_low, tx_idle, done_tick, err_tick;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       glitch_low = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int rule_viol = 0;

   vec_t vecs[5];

   // Wired-AND of host and device pull-downs on each line.
   assign ps2c = !(ps2c_drive_low || dev_clk_low || glitch_low);
   assign ps2d = !(ps2d_drive_low || dev_data_low);

   always #5 clk = ~clk;

   ps2_transmit #(
      .INHIBIT_CYCLES(INHIBIT),
      .FILTER_LEN    (FLEN),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ps2c          (ps2c),
      .ps2d          (ps2d),
      .wr_ps2        (wr_ps2),
      .din           (din),
      .ps2c_drive_low(ps2c_drive_low),
      .ps2d_drive_low(ps2d_drive_low),
      .tx_idle       (tx_idle),
      .done_tick     (done_tick),
      .err_tick      (err_tick)
   );

   always @(negedge clk) begin
      if (done_tick) done_cnt++;
      if (err_tick) err_cnt++;
      if ((done_tick || err_tick) && (tx_idle || ps2c_drive_low)) rule_viol++;
      if (done_tick && err_tick) rule_viol++;
   end

   // Start bit, LSB-first data, odd parity, stop bit as the device sees them.
   function automatic logic [10:0] expFrame(input logic [7:0] d);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d);
      @(negedge clk);
      wr_ps2 = 1'b1;
      din    = d;
      @(negedge clk);
      wr_ps2 = 1'b0;
   endtask

   task automatic measureRts(output int len, output int dlow_at);
      len = 0;
      dlow_at = 0;
      while (ps2c_drive_low && len < INHIBIT + 100) begin
         len++;
         if (ps2d_drive_low && dlow_at == 0) dlow_at = len;
         @(negedge clk);
      end
   endtask

   task automatic driveDevice(input logic ack, input bit glitch, input int reset_at,
                              output logic [10:0] bits);
      int w;
      bits = '0;
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < 11; k++) begin
         bits[k] = ps2d;
         if (glitch && k >= 2 && k <= 6) begin
            repeat (10) @(negedge clk);
            glitch_low = 1'b1;
            repeat (3) @(negedge clk);
            glitch_low = 1'b0;
            repeat (HALF - 13) @(negedge clk);
         end else if (glitch && k == 7) begin
            applyStimulus(8'h33);
            repeat (HALF - 2) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         if (k == 10) dev_data_low = ack;
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         if (reset_at == k) begin
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("reset_clk_release", ps2c_drive_low, 0);
            checkOutput("reset_data_release", ps2d_drive_low, 0);
            checkOutput("reset_tx_idle", tx_idle, 1);
            checkOutput("reset_no_ticks", {done_tick, err_tick}, 0);
            @(negedge clk);
            reset_n = 1'b1;
            dev_clk_low = 1'b0;
            dev_data_low = 1'b0;
            return;
         end
         dev_clk_low = 1'b0;
      end
      w = 0;
      while (!tx_idle && w < 4 * HALF) begin
         @(negedge clk);
         w++;
      end
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   task automatic runFrame(input string tag, input logic [7:0] d, input logic ack,
                           input logic [10:0] exp_bits, input int exp_done,
                           input int exp_err, input bit glitch);
      int d0, e0, len, dlow;
      logic [10:0] bits;
      d0 = done_cnt;
      e0 = err_cnt;
      applyStimulus(d);
      measureRts(len, dlow);
      checkOutput({tag, " rts_len"}, len, INHIBIT);
      checkOutput({tag, " rts_data_low_at"}, dlow, INHIBIT);
      driveDevice(ack, glitch, -1, bits);
      checkOutput({tag, " bits"}, bits, exp_bits);
      checkOutput({tag, " done_ticks"}, done_cnt - d0, exp_done);
      checkOutput({tag, " err_ticks"}, err_cnt - e0, exp_err);
      checkOutput({tag, " tx_idle"}, tx_idle, 1);
   endtask

   initial begin
      int d0, e0, len, dlow, cnt;
      logic [10:0] bits;
      logic [7:0] rd;
      logic ra;

      vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 11'h600, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 11'h7FE, 1, 0};
      vecs[3] = '{8'hA5, 1'b0, 11'h74A, 0, 1};
      vecs[4] = '{8'h01, 1'b1, 11'h402, 1, 0};

      repeat (5) @(negedge clk);
      checkOutput("reset_state", {ps2c_drive_low, ps2d_drive_low, tx_idle, done_tick, err_tick},
                  5'b00100);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      foreach (vecs[i])
         runFrame($sformatf("vec%0d", i), vecs[i].din, vecs[i].ack, vecs[i].exp_bits,
                  vecs[i].exp_done, vecs[i].exp_err, 1'b0);

      for (int i = 0; i < 3; i++) begin
         rd = 8'($urandom);
         ra = 1'($urandom % 2);
         runFrame($sformatf("rand%0d", i), rd, ra, expFrame(rd), ra ? 1 : 0, ra ? 0 : 1, 1'b0);
      end

      // Glitches on the clock line and a second write while busy.
      runFrame("glitch", 8'hED, 1'b1, expFrame(8'hED), 1, 0, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("busy_write_dropped", ps2c_drive_low, 0);

      // Device never clocks: the abort must land exactly TIMEOUT cycles after START.
      e0 = err_cnt;
      applyStimulus(8'h12);
      measureRts(len, dlow);
      cnt = 1;
      while (!err_tick && cnt < TIMEOUT + 50) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("timeout_cycles", cnt, TIMEOUT);
      checkOutput("timeout_lines_released", {ps2c_drive_low, ps2d_drive_low}, 0);
      @(negedge clk);
      checkOutput("timeout_idle", tx_idle, 1);
      checkOutput("timeout_err_count", err_cnt - e0, 1);

      // Reset in the middle of the data bits.
      d0 = done_cnt;
      e0 = err_cnt;
      applyStimulus(8'h5A);
      measureRts(len, dlow);
      driveDevice(1'b1, 1'b0, 4, bits);
      repeat (200) @(negedge clk);
      checkOutput("reset_midframe_ticks", (done_cnt - d0) + (err_cnt - e0), 0);
      checkOutput("reset_midframe_idle", tx_idle, 1);

      runFrame("after_reset", 8'hFF, 1'b1, expFrame(8'hFF), 1, 0, 1'b0);

      checkOutput("tick_rules", rule_viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
